// File: rtl/disp_pkg.sv
// Shared types and constants for the signed five-digit display path.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Digit codes understood by the seven-segment decoder beyond 0-9
    localparam logic [3:0] DIG_BLANK = 4'd10;
    localparam logic [3:0] DIG_MINUS = 4'd11;

    // Active-low anode patterns, leftmost position is the sign
    localparam logic [3:0] AN_SIGN = 4'b0111;
    localparam logic [3:0] AN_D0   = 4'b1011;
    localparam logic [3:0] AN_D1   = 4'b1101;
    localparam logic [3:0] AN_D2   = 4'b1110;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // One shift-add-3 iteration per magnitude bit
    localparam int N_ITER = 16;

    // Add 3 to every BCD nibble that is 5 or more before the next shift
    function automatic logic [19:0] bcd_adjust(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < 5; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter (shift-add-3).
// start loads the operand; done flags the edge that performs the last
// iteration; bcd holds the result until the next start.
module bin2bcd_seq
    import disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] din,
    output logic        done,
    output logic [19:0] bcd
);

    logic [15:0] bin;
    logic [19:0] acc;
    logic [19:0] adj;
    logic [3:0]  cnt;
    logic        run;

    assign adj  = bcd_adjust(acc);
    assign done = run && (cnt == 4'(N_ITER - 1));
    assign bcd  = acc;

    // Operand capture, then one adjust-and-shift per cycle while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin <= '0;
            acc <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            bin <= din;
            acc <= '0;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            {acc, bin} <= {adj[18:0], bin, 1'b0};
            cnt        <= cnt + 4'd1;
            if (cnt == 4'(N_ITER - 1))
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/disp_window_ctrl.sv
// Display sequencer: captures a signed magnitude, converts it to BCD,
// keeps a 3-digit scroll window and scans sign + window onto 4 anodes.
module disp_window_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_BITS = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        sign,
    input  logic        load,
    input  logic        sl,
    input  logic        sr,
    output logic        busy,
    output logic [1:0]  win,
    output logic [3:0]  an,
    output logic [3:0]  digit
);

    state_t              state, state_nx;
    logic                start;
    logic                cdone;
    logic [19:0]         bcd;
    logic                sign_shadow;
    logic                sign_reg;
    logic [3:0]          d [5];
    logic                sl_p0, sl_p1, sl_p2;
    logic                sr_p0, sr_p1, sr_p2;
    logic                sl_edge, sr_edge;
    logic [SCAN_BITS+1:0] scnt;
    logic [1:0]          sel;
    logic [2:0]          wi;
    logic [3:0]          an_nx, digit_nx;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .din   (value),
        .done  (cdone),
        .bcd   (bcd)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state; a load outside IDLE is dropped
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    start    = 1'b1;
                    state_nx = CONV;
                end
            end
            CONV:    if (cdone) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Sign shadow at load; displayed digits and sign change only in COMMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_shadow <= 1'b0;
            sign_reg    <= 1'b0;
            for (int i = 0; i < 5; i++) d[i] <= '0;
        end else begin
            if (start) sign_shadow <= sign;
            if (state == COMMIT) begin
                sign_reg <= sign_shadow;
                for (int i = 0; i < 5; i++) d[i] <= bcd[4*(4-i) +: 4];
            end
        end
    end

    // Button synchronisers (p0, p1) and previous-level flop (p2)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {sl_p0, sl_p1, sl_p2} <= 3'b000;
            {sr_p0, sr_p1, sr_p2} <= 3'b000;
        end else begin
            {sl_p0, sl_p1, sl_p2} <= {sl, sl_p0, sl_p1};
            {sr_p0, sr_p1, sr_p2} <= {sr, sr_p0, sr_p1};
        end
    end

    assign sl_edge = sl_p1 & ~sl_p2;
    assign sr_edge = sr_p1 & ~sr_p2;

    // Window offset: saturating steps, opposing edges cancel, COMMIT recentres
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= 2'd1;
        end else if (state == COMMIT) begin
            win <= 2'd1;
        end else if (sl_edge && !sr_edge) begin
            if (win < 2'd2) win <= win + 2'd1;
        end else if (sr_edge && !sl_edge) begin
            if (win > 2'd0) win <= win - 2'd1;
        end
    end

    // Free-running scan counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) scnt <= '0;
        else        scnt <= scnt + 1'b1;
    end

    assign sel = scnt[SCAN_BITS+1:SCAN_BITS];
    assign wi  = {1'b0, win};

    // Anode/digit selection for the current scan position
    always_comb begin
        an_nx    = AN_OFF;
        digit_nx = DIG_BLANK;
        case (sel)
            2'd0: begin
                an_nx    = AN_SIGN;
                digit_nx = sign_reg ? DIG_MINUS : DIG_BLANK;
            end
            2'd1: begin
                an_nx    = AN_D0;
                digit_nx = d[wi];
            end
            2'd2: begin
                an_nx    = AN_D1;
                digit_nx = d[wi + 3'd1];
            end
            default: begin
                an_nx    = AN_D2;
                digit_nx = d[wi + 3'd2];
            end
        endcase
    end

    // Output stage: anode and digit registered together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an    <= AN_OFF;
            digit <= DIG_BLANK;
        end else begin
            an    <= an_nx;
            digit <= digit_nx;
        end
    end

endmodule

// File: tb/tb_disp_window_ctrl.sv
// Self-checking bench for disp_window_ctrl with a short scan period.
module tb_disp_window_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] value = '0;
    logic        sign = 1'b0;
    logic        load = 1'b0;
    logic        sl = 1'b0;
    logic        sr = 1'b0;
    logic        busy;
    logic [1:0]  win;
    logic [3:0]  an;
    logic [3:0]  digit;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: decimal digits of the committed value, sign, window
    int md [5];
    int msign;
    int mwin;

    disp_window_ctrl #(.SCAN_BITS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .value (value),
        .sign  (sign),
        .load  (load),
        .sl    (sl),
        .sr    (sr),
        .busy  (busy),
        .win   (win),
        .an    (an),
        .digit (digit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_model(input int v, input int s);
        int div [5];
        div = '{10000, 1000, 100, 10, 1};
        for (int i = 0; i < 5; i++) md[i] = (v / div[i]) % 10;
        msign = s;
        mwin  = 1;
    endtask

    // Watch one full scan and compare every anode/digit pair to the model
    task automatic check_scan(input string tag);
        logic [3:0] seen;
        seen = 4'h0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            case (an)
                4'b0111: begin seen[0] = 1'b1; chk({tag, "_sign"}, digit, msign ? 11 : 10); end
                4'b1011: begin seen[1] = 1'b1; chk({tag, "_dig0"}, digit, md[mwin]); end
                4'b1101: begin seen[2] = 1'b1; chk({tag, "_dig1"}, digit, md[mwin+1]); end
                4'b1110: begin seen[3] = 1'b1; chk({tag, "_dig2"}, digit, md[mwin+2]); end
                default: chk({tag, "_an"}, an, 4'b0111);
            endcase
        end
        chk({tag, "_seen"}, seen, 4'hf);
    endtask

    // Load pulse; optionally pokes a second load 'poke' cycles into busy
    task automatic do_load(input int v, input bit s, input int poke);
        int n;
        @(negedge clk);
        value = 16'(v); sign = s; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (poke > 0 && n == poke) begin value = 16'd0; sign = 1'b0; load = 1'b1; end
            else load = 1'b0;
            @(negedge clk);
        end
        load = 1'b0;
        chk("busy_len", n, 17);
        set_model(v, int'(s));
        chk("win_commit", win, 1);
        repeat (2) @(negedge clk);
    endtask

    // Button press with exact 3-cycle latency check and single-step check
    task automatic press(input bit l, input bit r, input int hold);
        int exp;
        if (l && !r)      exp = (mwin < 2) ? mwin + 1 : 2;
        else if (r && !l) exp = (mwin > 0) ? mwin - 1 : 0;
        else              exp = mwin;
        @(negedge clk);
        sl = l; sr = r;
        @(negedge clk); chk("win_lat1", win, mwin);
        @(negedge clk); chk("win_lat2", win, mwin);
        @(negedge clk); chk("win_step", win, exp);
        if (hold > 3) repeat (hold - 3) @(negedge clk);
        sl = 1'b0; sr = 1'b0;
        repeat (4) @(negedge clk);
        chk("win_final", win, exp);
        mwin = exp;
    endtask

    initial begin
        set_model(0, 0);

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_an", an, 4'b1111);
        chk("rst_digit", digit, 10);
        chk("rst_busy", busy, 0);
        chk("rst_win", win, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_an", an, 4'b0111);
        chk("post_rst_digit", digit, 10);
        check_scan("rst_scan");

        // 12345 and scrolling
        do_load(12345, 1'b0, 0);
        check_scan("v12345");
        press(1'b1, 1'b0, 3);
        press(1'b1, 1'b0, 3);
        press(1'b1, 1'b0, 5);
        check_scan("v12345_w2");
        press(1'b0, 1'b1, 3);
        press(1'b0, 1'b1, 4);
        press(1'b0, 1'b1, 3);
        check_scan("v12345_w0");
        press(1'b1, 1'b0, 100);
        check_scan("v12345_held");

        // Max negative with an ignored second load
        do_load(65535, 1'b1, 5);
        check_scan("v65535");
        press(1'b1, 1'b1, 3);
        press(1'b1, 1'b0, 3);
        press(1'b1, 1'b1, 4);
        check_scan("v65535_w2");

        // Zero, then a reload from win=2 recentres the window
        do_load(0, 1'b0, 0);
        check_scan("v0");
        press(1'b1, 1'b0, 3);
        do_load(908, 1'b0, 0);
        check_scan("v908");

        // Randomised loads and scrolls
        for (int it = 0; it < 6; it++) begin
            do_load(int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 0);
            check_scan("rnd_load");
            for (int j = 0; j < 3; j++) begin
                press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(3, 8)));
            end
            check_scan("rnd_scroll");
        end

        // Asynchronous reset in the middle of a conversion
        @(negedge clk);
        value = 16'd54321; sign = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_an", an, 4'b1111);
        chk("midrst_digit", digit, 10);
        chk("midrst_win", win, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_model(0, 0);
        repeat (30) @(negedge clk);
        chk("midrst_idle", busy, 0);
        check_scan("midrst_scan");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/disp_window_ctrl.md
# disp_window_ctrl

Sequencing controller for the five-digit signed display path. It captures a 16-bit unsigned magnitude and a sign on a load pulse, converts the magnitude to five BCD digits with a multi-cycle shift-add-3 conversion, and holds a 3-digit scroll window that steps on left/right button edges. It time-multiplexes the sign position and the three visible digits onto the 4-anode display. It sits between the calculator result/switch logic and the combinational seven-segment decoder, and emits digit codes for that decoder.

## Interface
- SCAN_BITS, 18: per-digit dwell is 2^SCAN_BITS clk cycles; scan counter width is SCAN_BITS+2.
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- value  input  16  unsigned magnitude, sampled on load.
- sign  input  1  1 = negative, sampled on load.
- load  input  1  single-cycle start pulse.
- sl  input  1  raw scroll-left button level.
- sr  input  1  raw scroll-right button level.
- busy  output  1  conversion in progress.
- win  output  2  window offset, 0..2.
- an  output  4  anode enables, active-low, registered.
- digit  output  4  digit code to the decoder, registered: 0-9 digit, 10 blank, 11 minus.

## Operation
- FSM states:
  - IDLE: load=1 captures value and sign into shadow registers and goes to CONV.
  - CONV: 16 iterations. Each iteration adds 3 to every BCD nibble ≥5, then shifts {bcd[19:0], bin[15:0]} left by 1. After the 16th iteration, go to COMMIT.
  - COMMIT: write d4..d0 (d0 = ten-thousands, d4 = units), write sign_reg, force win=1, go to IDLE.
- busy=1 in CONV and COMMIT. A load seen in CONV or COMMIT is ignored and not queued.
- The displayed digits and sign stay at the previous committed values until COMMIT.
- The conversion is exact for 0..65535, so d0 ≤ 6.
- Buttons: each of sl and sr is passed through a 2-flop synchroniser, then rising-edge detected. A held button gives exactly one step.
- Window stepping:
  - sl edge: win+1, saturating at 2.
  - sr edge: win−1, saturating at 0.
  - sl and sr edges in the same cycle: no change.
  - Edges are honoured in every state except COMMIT. In COMMIT the forced win=1 wins.
- Visible digits are d[win], d[win+1], d[win+2].
- Scan: a free-running counter scnt, where sel = scnt[SCAN_BITS+1:SCAN_BITS].
  - sel 0: an=0111, digit = sign_reg ? 11 : 10.
  - sel 1: an=1011, digit = d[win].
  - sel 2: an=1101, digit = d[win+1].
  - sel 3: an=1110, digit = d[win+2].
- Reset values: state IDLE, busy 0, win 1, d0..d4 = 0, sign_reg 0, scnt 0, an 1111, digit 10, synchroniser and edge flops 0.

## Timing
- load sampled at edge k:
  - busy is high after edge k.
  - The CONV iterations occur at edges k+1..k+16.
  - COMMIT updates the digits at edge k+17, and busy falls after edge k+17.
  - Load-to-new-display latency is 17 cycles, plus up to one registered scan cycle.
- an and digit lag sel by exactly 1 cycle. They change together, so there is never a mixed anode/digit pair.
- Button edge to win change: 3 cycles (2 sync + 1 edge/update).
- A back-to-back load is accepted only once busy=0, i.e. at edge k+18 at the earliest.
- rst_n low at any point, including mid-CONV: all state returns to reset values immediately, without waiting for clk. The partial conversion is discarded.

## Structure
- Package disp_pkg holds:
  - state enum {IDLE, CONV, COMMIT};
  - DIG_BLANK=4'd10 and DIG_MINUS=4'd11;
  - the AN_SIGN/AN_D0/AN_D1/AN_D2 patterns;
  - the iteration count constant 16.
- Sub-module bin2bcd_seq holds the shift-add-3 datapath and the iteration counter, with handshake start/done and result bcd[19:0].
- The top level holds the FSM, window, synchronisers, scan and output registers.

## Test plan
- Reset: assert rst_n=0, then release. Required: an=1111, digit=10, busy=0, win=1; after 2 cycles, an=0111, digit=10.
- Load with SCAN_BITS=2, value=12345, sign=0. Required: busy high for exactly 17 cycles; the scan then shows the codes 10, 2, 3, 4 on an 0111, 1011, 1101, 1110.
- Scrolling after that load:
  - Two sl edges, then a third: win=2 both times; digits 3, 4, 5.
  - Three sr edges: win=0; digits 1, 2, 3.
  - One sl held 100 cycles: exactly one step.
- Simultaneous events:
  - value=65535, sign=1: codes 11, 5, 5, 3.
  - A second load 5 cycles later with value=0 is ignored.
  - sl and sr rising in the same cycle leave win unchanged.
- Zero and re-load: value=0, sign=0 gives 10, 0, 0, 0. Then win=2 followed by a new load forces win=1 at COMMIT.
- Mid-conversion reset: rst_n low at cycle k+8 of a conversion. Required: busy=0 and d=0 immediately; an=1111 with no clock edge; no stale commit after release.
